// File: rtl/uart_defs.sv
// Shared UART definitions: parity encodings and FSM state encodings.
// Reused by the transmitter and the future receiver.
package uart_defs;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with full/empty/level outputs.
// Push is ignored when full; pop is ignored when empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer advance and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// Buffered UART transmitter with runtime baud divisor, parity and stop bits.
// Each frame latches its configuration when its character is popped.
module uart_tx_gen
    import uart_defs::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [LVL_W-1:0]     fifo_level
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     data_cnt_q, data_cnt_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 bit_done;
    logic                 frame_end;
    logic                 load;
    logic [DIV_W-1:0]     div_clamped;
    logic                 cfg_par_en;
    logic                 cfg_par_odd;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (load),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready    = !fifo_full;
    assign uart_tx     = tx_q;
    assign busy        = (state_q != ST_IDLE) || (fifo_level != '0);
    assign bit_done    = (bit_cnt_q == '0);
    assign frame_end   = (state_q == ST_STOP) && bit_done
                         && (stop2_q || !two_stop_q);
    assign load        = ((state_q == ST_IDLE) || frame_end) && !fifo_empty;
    assign div_clamped = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;

    // Decode the parity selection; the reserved code behaves as none
    always_comb begin
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
        case (parity_mode)
            PAR_NONE: cfg_par_en = 1'b0;
            PAR_EVEN: cfg_par_en = 1'b1;
            PAR_ODD: begin
                cfg_par_en  = 1'b1;
                cfg_par_odd = 1'b1;
            end
            default:  cfg_par_en = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (data_cnt_q == LAST_BIT)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (frame_end) begin
                    state_d = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: baud counter, shifter, line level and frame config
    always_comb begin
        shift_d    = shift_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        if (state_q != ST_IDLE) begin
            bit_cnt_d = bit_done ? (div_q - 1'b1) : (bit_cnt_q - 1'b1);
        end
        if (load) begin
            shift_d    = head;
            div_d      = div_clamped;
            bit_cnt_d  = div_clamped - 1'b1;
            par_en_d   = cfg_par_en;
            par_bit_d  = (^head) ^ cfg_par_odd;
            two_stop_d = two_stop;
            tx_d       = 1'b0;
        end else if (bit_done) begin
            unique case (state_q)
                ST_START: begin
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                    data_cnt_d = '0;
                end
                ST_DATA: begin
                    if (data_cnt_q == LAST_BIT) begin
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                        stop2_d = 1'b0;
                    end else begin
                        tx_d       = shift_q[0];
                        shift_d    = shift_q >> 1;
                        data_cnt_d = data_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    stop2_d = 1'b0;
                end
                ST_STOP: begin
                    tx_d    = 1'b1;
                    stop2_d = 1'b1;
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    // Datapath registers; line idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            div_q      <= MIN_DIV;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: frame vector table plus
// hand-written back-to-back, FIFO-full, config-change and reset sequences.
module tb_uart_tx_gen;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic [DW-1:0] baud_div;
    logic [1:0]    parity_mode;
    logic          two_stop;
    logic          uart_tx;
    logic          busy;
    logic [LW-1:0] fifo_level;

    int tests = 0;
    int fails = 0;

    uart_tx_gen #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // bits[0] is the first bit on the line (start bit)
    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        int          eff;
        logic [1:0]  par;
        logic        two;
        logic [0:11] bits;
        int          n;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] chars[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push1(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Compare the line cycle by cycle against an expected frame
    task automatic wave(input logic [0:11] bits, input int n, input int div,
                        input bit pre, input string name);
        int errs;
        int first;
        errs  = 0;
        first = -1;
        for (int k = 0; k < n * div; k++) begin
            if (!(pre && k == 0)) tick();
            if (uart_tx !== bits[k / div]) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        check($sformatf("%s bad cycles (first %0d)", name, first), errs, 0);
    endtask

    // Decode one 8N frame by mid-bit sampling
    task automatic recv(input int div, output logic [7:0] d, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        d  = '0;
        while (uart_tx !== 1'b0 && w < 3000) begin
            tick();
            w++;
        end
        if (w >= 3000) begin
            ok = 1'b0;
            return;
        end
        repeat (div / 2) tick();
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat (div) tick();
            d[b] = uart_tx;
        end
        repeat (div) tick();
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;

        vecs[0] = '{8'h55, 16'd4, 4, 2'b00, 1'b0, 12'b010101010111, 10};
        vecs[1] = '{8'h03, 16'd4, 4, 2'b01, 1'b0, 12'b011000000011, 11};
        vecs[2] = '{8'h03, 16'd4, 4, 2'b10, 1'b0, 12'b011000000111, 11};
        vecs[3] = '{8'h07, 16'd4, 4, 2'b01, 1'b0, 12'b011100000111, 11};
        vecs[4] = '{8'h00, 16'd0, 2, 2'b00, 1'b1, 12'b000000000111, 11};
        vecs[5] = '{8'hFF, 16'd1, 2, 2'b10, 1'b1, 12'b011111111111, 12};
        vecs[6] = '{8'hA5, 16'd3, 3, 2'b11, 1'b0, 12'b010100101111, 10};
        vecs[7] = '{8'h80, 16'd5, 5, 2'b01, 1'b0, 12'b000000001111, 11};

        chars[0] = 8'h11;
        chars[1] = 8'h22;
        chars[2] = 8'h3C;
        chars[3] = 8'h4B;
        chars[4] = 8'h5A;
        chars[5] = 8'hE7;

        repeat (3) tick();
        check("reset uart_tx", int'(uart_tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset fifo_level", int'(fifo_level), 0);
        check("reset in_ready", int'(in_ready), 1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            baud_div    = vecs[i].div;
            parity_mode = vecs[i].par;
            two_stop    = vecs[i].two;
            push1(vecs[i].data);
            wave(vecs[i].bits, vecs[i].n, vecs[i].eff, 1'b0,
                 $sformatf("vec%0d wave", i));
            tick();
            check($sformatf("vec%0d busy after", i), int'(busy), 0);
            check($sformatf("vec%0d idle line", i), int'(uart_tx), 1);
        end

        // Back-to-back, two stop bits, div 3: no idle gap between frames
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        two_stop    = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'hA5;
        tick();
        in_data     = 8'h0F;
        tick();
        in_valid    = 1'b0;
        wave(12'b010100101111, 11, 3, 1'b1, "b2b A5");
        wave(12'b011110000111, 11, 3, 1'b0, "b2b 0F");
        tick();
        check("b2b busy after", int'(busy), 0);

        // FIFO full with in_valid held high
        baud_div    = 16'd10;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        fork
            begin : prod
                int idx;
                int low;
                int lvl_at_full;
                idx         = 0;
                low         = 0;
                lvl_at_full = -1;
                in_valid    = 1'b1;
                in_data     = chars[0];
                for (int c = 0; c < 400 && idx < 6; c++) begin
                    logic acc;
                    acc = in_ready;
                    tick();
                    if (acc) begin
                        idx++;
                        if (idx < 6) in_data = chars[idx];
                        else in_valid = 1'b0;
                    end
                    if (idx < 6 && !in_ready) begin
                        low++;
                        if (lvl_at_full < 0) lvl_at_full = int'(fifo_level);
                    end
                end
                in_valid = 1'b0;
                check("fifo accepted count", idx, 6);
                check("fifo level when ready drops", lvl_at_full, 4);
                check("fifo ready low cycles", low, 97);
            end
            begin : cons
                for (int f = 0; f < 6; f++) begin
                    logic [7:0] d;
                    bit         ok;
                    recv(10, d, ok);
                    check($sformatf("fifo char%0d", f),
                          ok ? int'(d) : -1, int'(chars[f]));
                end
            end
        join
        repeat (10) tick();
        check("fifo drained busy", int'(busy), 0);
        check("fifo drained level", int'(fifo_level), 0);

        // Runtime divisor change only affects the next frame
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h55;
        tick();
        in_data     = 8'h33;
        tick();
        in_valid    = 1'b0;
        fork
            wave(12'b010101010111, 10, 4, 1'b1, "cfg frame1 div4");
            begin
                repeat (10) tick();
                baud_div = 16'd8;
            end
        join
        wave(12'b011001100111, 10, 8, 1'b0, "cfg frame2 div8");
        tick();
        check("cfg busy after", int'(busy), 0);

        // Reset during DATA with three characters queued
        baud_div = 16'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = chars[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        check("pre-reset level", int'(fifo_level), 3);
        reset = 1'b1;
        tick();
        check("midreset uart_tx", int'(uart_tx), 1);
        check("midreset fifo_level", int'(fifo_level), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset in_ready", int'(in_ready), 1);
        reset = 1'b0;
        begin
            int lows;
            lows = 0;
            repeat (200) begin
                tick();
                if (uart_tx !== 1'b1) lows++;
            end
            check("post-reset line low cycles", lows, 0);
        end
        check("post-reset busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
